// File: rtl/reversible_pipelined_adder.sv
// Reversible (Peres-style) ripple adder split into PIPE_STAGES registered carry segments.
// Define REV_UNCOMPUTE_EN to add the mode port selecting the inverse S - A - cin.
module reversible_pipelined_adder #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
`ifdef REV_UNCOMPUTE_EN
    input  logic             mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [CNT_W-1:0] op_count
);

    localparam int C = WIDTH / PIPE_STAGES;
    localparam int L = PIPE_STAGES - 1;

    logic                   run;
    logic                   mode_i;
    logic [PIPE_STAGES-1:0] vld;
    logic [PIPE_STAGES-1:0] ld;
    logic [PIPE_STAGES-1:0] rm;
    logic [PIPE_STAGES-1:0] rc;
    logic [WIDTH-1:0]       ra [PIPE_STAGES];
    logic [WIDTH-1:0]       rb [PIPE_STAGES];
    logic [WIDTH-1:0]       rs [PIPE_STAGES];

    logic [PIPE_STAGES-1:0] sv;
    logic [PIPE_STAGES-1:0] sm;
    logic [PIPE_STAGES-1:0] sc;
    logic [PIPE_STAGES-1:0] nc;
    logic [WIDTH-1:0]       sa [PIPE_STAGES];
    logic [WIDTH-1:0]       sb [PIPE_STAGES];
    logic [WIDTH-1:0]       ss [PIPE_STAGES];
    logic [WIDTH-1:0]       ns [PIPE_STAGES];

`ifdef REV_UNCOMPUTE_EN
    assign mode_i = mode;
`else
    assign mode_i = 1'b0;
`endif

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_comb begin
        ld = '0;
        ld[L] = !vld[L] || out_ready;
        for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
            ld[k] = !vld[k] || ld[k+1];
        end
    end

    assign in_ready = ld[0] && run;

    // Inverse mode feeds ~cin as the initial carry; a is inverted per cell.
    always_comb begin
        sv[0] = in_valid && in_ready;
        sm[0] = mode_i;
        sc[0] = cin ^ mode_i;
        sa[0] = a_in;
        sb[0] = b_in;
        ss[0] = '0;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            sv[k] = vld[k-1];
            sm[k] = rm[k-1];
            sc[k] = rc[k-1];
            sa[k] = ra[k-1];
            sb[k] = rb[k-1];
            ss[k] = rs[k-1];
        end
    end

    always_comb begin
        logic x;
        logic y;
        x = 1'b0;
        y = 1'b0;
        nc = '0;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            ns[k] = ss[k];
            nc[k] = sc[k];
            for (int i = 0; i < C; i++) begin
                x = sa[k][k*C+i] ^ sm[k];
                y = sb[k][k*C+i];
                ns[k][k*C+i] = x ^ y ^ nc[k];
                nc[k] = (x & y) ^ (nc[k] & (x ^ y));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            rm  <= '0;
            rc  <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                ra[k] <= '0;
                rb[k] <= '0;
                rs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (ld[k]) begin
                    vld[k] <= sv[k];
                    if (sv[k]) begin
                        rm[k] <= sm[k];
                        rc[k] <= nc[k];
                        ra[k] <= sa[k];
                        rb[k] <= sb[k];
                        rs[k] <= ns[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + 1'b1;
        end
    end

    assign out_valid = vld[L];
    assign a_out     = ra[L];
    assign b_out     = rb[L];
    assign sum       = rs[L];
    assign cout      = rc[L] ^ rm[L];

endmodule

// File: tb/tb_reversible_pipelined_adder.sv
// Directed-vector bench for reversible_pipelined_adder: streaming, stall,
// mid-flight reset, exhaustive 4-bit sweeps and (optionally) the inverse mode.
`timescale 1ns/1ps
module tb_reversible_pipelined_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  a_out;
    logic [7:0]  b_out;
    logic [7:0]  sum;
    logic        cout;
    logic [15:0] op_count;
`ifdef REV_UNCOMPUTE_EN
    logic        mode;
`endif

    logic [3:0]  x_a;
    logic [3:0]  x_b;
    logic        x_cin;
    logic        x_valid;
    logic [2:0]  x_ir;
    logic [2:0]  x_ov;
    logic [2:0]  x_co;
    logic [3:0]  x_sum [3];
    logic [3:0]  x_ao [3];
    logic [3:0]  x_bo [3];
    logic [15:0] x_cnt [3];

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    reversible_pipelined_adder #(
        .WIDTH(8), .PIPE_STAGES(2), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef REV_UNCOMPUTE_EN
        .mode(mode),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .sum(sum), .cout(cout),
        .op_count(op_count)
    );

    for (genvar g = 0; g < 3; g++) begin : g_x
        reversible_pipelined_adder #(
            .WIDTH(4), .PIPE_STAGES(1 << g), .CNT_W(16)
        ) u_x (
            .clk(clk), .rst_n(rst_n),
            .in_valid(x_valid), .in_ready(x_ir[g]),
            .a_in(x_a), .b_in(x_b), .cin(x_cin),
`ifdef REV_UNCOMPUTE_EN
            .mode(1'b0),
`endif
            .out_valid(x_ov[g]), .out_ready(1'b1),
            .a_out(x_ao[g]), .b_out(x_bo[g]), .sum(x_sum[g]),
            .cout(x_co[g]), .op_count(x_cnt[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_res(input string name, input vec_t v);
        chk(name, {out_valid, cout, sum, a_out, b_out},
            {1'b1, v.co, v.s, v.a, v.b});
    endtask

    task automatic drive(input vec_t v);
        a_in = v.a;
        b_in = v.b;
        cin = v.c;
        in_valid = 1'b1;
    endtask

`ifdef REV_UNCOMPUTE_EN
    task automatic run_one(input logic [7:0] ta, input logic [7:0] tb,
                           input logic tc, output logic [7:0] rs,
                           output logic rco);
        a_in = ta;
        b_in = tb;
        cin = tc;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
        chk("rt_valid", out_valid, 1);
        chk("rt_aout", a_out, ta);
        rs = sum;
        rco = cout;
        @(negedge clk);
    endtask
`endif

    vec_t tbl [8];
    vec_t bp [3];
    vec_t v0;
    vec_t v1;

    initial begin
        int idx;
        logic [8:0] xv;
        logic [4:0] xr;

        tbl[0] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        tbl[1] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'h0F, 8'hF1, 1'b1, 8'h01, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        tbl[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        tbl[7] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        bp[0]  = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        bp[1]  = '{8'hF0, 8'h20, 1'b0, 8'h10, 1'b1};
        bp[2]  = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        v0     = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        v1     = '{8'h11, 8'h22, 1'b0, 8'h33, 1'b0};

        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        cin = 1'b0;
        out_ready = 1'b0;
        x_valid = 1'b0;
        x_a = '0;
        x_b = '0;
        x_cin = 1'b0;
`ifdef REV_UNCOMPUTE_EN
        mode = 1'b0;
`endif

        repeat (2) @(negedge clk);
        chk("rst_state", {in_ready, out_valid, cout, sum, a_out, b_out, op_count}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", in_ready, 1);

        // Single add with wraparound into cout.
        out_ready = 1'b1;
        drive(v0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("basic_lat1", out_valid, 0);
        @(negedge clk);
        chk_res("basic_res", v0);
        chk("basic_cnt0", op_count, 0);
        exp_cnt = 1;
        @(negedge clk);
        chk("basic_cnt1", {out_valid, op_count}, {1'b0, 16'd1});

        // Back-to-back streaming through the vector table.
        for (int j = 0; j < 10; j++) begin
            if (j >= 2) begin
                chk_res("stream_res", tbl[j-2]);
                chk("stream_cnt", op_count, exp_cnt);
                exp_cnt++;
            end else begin
                chk("stream_idle", out_valid, 0);
            end
            if (j < 8) begin
                drive(tbl[j]);
                #1;
                chk("stream_ready", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream_end", {out_valid, op_count}, {1'b0, exp_cnt[15:0]});

        // Backpressure: two fill the pipe, third waits for the pop.
        out_ready = 1'b0;
        drive(bp[0]);
        #1 chk("bp_rdy0", in_ready, 1);
        @(negedge clk);
        drive(bp[1]);
        #1 chk("bp_rdy1", in_ready, 1);
        @(negedge clk);
        drive(bp[2]);
        #1 chk("bp_full", in_ready, 0);
        chk_res("bp_hold0", bp[0]);
        @(negedge clk);
        #1 chk("bp_full2", in_ready, 0);
        chk_res("bp_hold1", bp[0]);
        chk("bp_cnt_hold", op_count, exp_cnt);
        out_ready = 1'b1;
        #1 chk("bp_pop_ready", in_ready, 1);
        exp_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        chk_res("bp_out1", bp[1]);
        exp_cnt++;
        @(negedge clk);
        chk_res("bp_out2", bp[2]);
        exp_cnt++;
        @(negedge clk);
        chk("bp_end", {out_valid, op_count}, {1'b0, exp_cnt[15:0]});

        // Reset with two operations in flight.
        out_ready = 1'b0;
        drive(v1);
        @(negedge clk);
        drive(tbl[0]);
        @(negedge clk);
        in_valid = 1'b0;
        chk_res("mid_pre", v1);
        rst_n = 1'b0;
        #1 chk("mid_rst", {in_ready, out_valid, cout, sum, a_out, b_out, op_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_cnt = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("mid_after", {in_ready, out_valid, op_count}, {1'b1, 1'b0, 16'd0});
        end

`ifdef REV_UNCOMPUTE_EN
        begin
            logic [7:0] rs;
            logic       rco;
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            logic [8:0] t;
            mode = 1'b1;
            run_one(8'h05, 8'h03, 1'b0, rs, rco);
            chk("inv_sum", {rco, rs}, {1'b1, 8'hFE});
            for (int j = 0; j < 6; j++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
                t = ra + rb + rc;
                mode = 1'b0;
                run_one(ra, rb, rc, rs, rco);
                chk("rt_add", {rco, rs}, t);
                mode = 1'b1;
                run_one(ra, rs, rc, rs, rco);
                chk("rt_recover", rs, rb);
            end
            mode = 1'b0;
        end
`endif

        // Exhaustive 4-bit sweep for PIPE_STAGES 1, 2 and 4 in parallel.
        for (int j = 0; j < 516; j++) begin
            for (int g = 0; g < 3; g++) begin
                idx = j - (1 << g);
                if (idx >= 0 && idx < 512) begin
                    xv = idx[8:0];
                    xr = xv[8:5] + xv[4:1] + xv[0];
                    chk("exh", {x_ov[g], x_co[g], x_sum[g], x_ao[g], x_bo[g]},
                        {1'b1, xr, xv[8:5], xv[4:1]});
                end else begin
                    chk("exh_idle", x_ov[g], 0);
                end
            end
            if (j < 512) begin
                {x_a, x_b, x_cin} = j[8:0];
                x_valid = 1'b1;
            end else begin
                x_valid = 1'b0;
            end
            @(negedge clk);
        end
        for (int g = 0; g < 3; g++) begin
            chk("exh_cnt", x_cnt[g], 512);
        end
        chk("exh_ready", x_ir, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
